// File: rtl/floating_point_multiplier_array.sv
// Multi-lane floating-point multiplier, 3-stage valid/ready pipeline.
// S1 decodes operands and forms the significand product, S2 normalises and
// rounds, S3 is the output register.
// Compile-time option: FP_MUL_ARRAY_RNE_EN selects round-to-nearest-even;
// when undefined, rounding is to nearest with ties away from zero.
module floating_point_multiplier_array #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH = 23,
    parameter int unsigned LANES      = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [LANES*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]     fp_a_i,
    input  logic [LANES*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]     fp_b_i,
    input  logic [LANES-1:0]                              lane_en_i,
    input  logic                                          valid_i,
    output logic                                          ready_o,
    output logic [LANES*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]     fp_o,
    output logic [LANES*3-1:0]                            flags_o,
    output logic                                          valid_o,
    input  logic                                          ready_i
);

    localparam int unsigned FPW = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int unsigned P   = FRAC_WIDTH + 1;
    localparam int unsigned PW  = 2 * P;
    localparam int unsigned EW  = EXP_WIDTH + 2;
    localparam int unsigned RW  = FRAC_WIDTH + 1;

    localparam logic signed [EW-1:0]   BIAS      = EW'(2 ** (EXP_WIDTH - 1) - 1);
    localparam logic signed [EW-1:0]   EXP_ZERO  = '0;
    localparam logic signed [EW-1:0]   EXP_INF   = EW'(2 ** EXP_WIDTH - 1);
    localparam logic [EXP_WIDTH-1:0]   EXP_ONES  = '1;
    localparam logic [FRAC_WIDTH-1:0]  FRAC_ZERO = '0;
    localparam logic [FRAC_WIDTH-1:0]  QNAN_FRAC = {1'b1, {(FRAC_WIDTH-1){1'b0}}};

    logic s1_v, s2_v, s3_v;
    logic s1_adv, s2_adv, s3_adv;

    // Stage advance chain: a stage moves when empty or when its successor moves
    assign s3_adv  = !s3_v || ready_i;
    assign s2_adv  = !s2_v || s3_adv;
    assign s1_adv  = !s1_v || s2_adv;
    assign ready_o = rst_ni && s1_adv;
    assign valid_o = s3_v;

    // Stage valid bits; reset discards every in-flight beat
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            if (s1_adv) s1_v <= valid_i;
            if (s2_adv) s2_v <= s1_v;
            if (s3_adv) s3_v <= s2_v;
        end
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic                    sa, sb;
        logic [EXP_WIDTH-1:0]    ea, eb;
        logic [FRAC_WIDTH-1:0]   fa, fb;
        logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

        logic                    s1_en, s1_sign, s1_nan, s1_inf, s1_zero;
        logic signed [EW-1:0]    s1_exp;
        logic [PW-1:0]           s1_prod;

        logic                    carry, guard, sticky, tie_up, round_up;
        logic [PW-2:0]           norm;
        logic [FRAC_WIDTH-1:0]   frac_t;
        logic [RW-1:0]           rnd;
        logic signed [EW-1:0]    exp_f;
        logic [FPW-1:0]          res_fp;
        logic [2:0]              res_fl;

        logic [FPW-1:0]          s2_fp, s3_fp;
        logic [2:0]              s2_fl, s3_fl;

        assign {sa, ea, fa} = fp_a_i[n*FPW +: FPW];
        assign {sb, eb, fb} = fp_b_i[n*FPW +: FPW];

        // Operand classes; exponent zero (including subnormals) reads as zero
        assign a_zero = (ea == '0);
        assign b_zero = (eb == '0);
        assign a_inf  = (ea == EXP_ONES) && (fa == '0);
        assign b_inf  = (eb == EXP_ONES) && (fb == '0);
        assign a_nan  = (ea == EXP_ONES) && (fa != '0);
        assign b_nan  = (eb == EXP_ONES) && (fb != '0);

        // S1: capture operand classes, biased exponent sum and significand product
        always_ff @(posedge clk_i) begin
            if (s1_adv && valid_i) begin
                s1_en   <= lane_en_i[n];
                s1_sign <= sa ^ sb;
                s1_nan  <= a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero);
                s1_inf  <= a_inf || b_inf;
                s1_zero <= a_zero || b_zero;
                s1_exp  <= $signed(EW'(ea)) + $signed(EW'(eb)) - BIAS;
                s1_prod <= PW'({1'b1, fa}) * PW'({1'b1, fb});
            end
        end

        // Normalise on the product carry, then round; an exact half rounds up
        // unless ties-to-even keeps an even fraction
        always_comb begin
            carry  = s1_prod[PW-1];
            norm   = carry ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};
            frac_t = norm[PW-2 -: FRAC_WIDTH];
            guard  = norm[P-1];
            sticky = |norm[P-2:0];
`ifdef FP_MUL_ARRAY_RNE_EN
            tie_up = frac_t[0];
`else
            tie_up = 1'b1;
`endif
            round_up = guard && (sticky || tie_up);
            rnd      = {1'b0, frac_t} + RW'(round_up);
            exp_f    = s1_exp + $signed(EW'(carry)) + $signed(EW'(rnd[FRAC_WIDTH]));
        end

        // Special-case selection and exponent range checks
        always_comb begin
            res_fp = '0;
            res_fl = '0;
            if (s1_en) begin
                if (s1_nan) begin
                    res_fp = {1'b0, EXP_ONES, QNAN_FRAC};
                    res_fl = 3'b100;
                end else if (s1_inf) begin
                    res_fp = {s1_sign, EXP_ONES, FRAC_ZERO};
                end else if (s1_zero) begin
                    res_fp = {s1_sign, {(FPW-1){1'b0}}};
                end else if (exp_f <= EXP_ZERO) begin
                    res_fp = {s1_sign, {(FPW-1){1'b0}}};
                    res_fl = 3'b001;
                end else if (exp_f >= EXP_INF) begin
                    res_fp = {s1_sign, EXP_ONES, FRAC_ZERO};
                    res_fl = 3'b010;
                end else begin
                    res_fp = {s1_sign, exp_f[EXP_WIDTH-1:0], rnd[FRAC_WIDTH-1:0]};
                end
            end
        end

        // S2: hold the finished lane result
        always_ff @(posedge clk_i) begin
            if (s2_adv && s1_v) begin
                s2_fp <= res_fp;
                s2_fl <= res_fl;
            end
        end

        // S3: output register, cleared on reset and held while stalled
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                s3_fp <= '0;
                s3_fl <= '0;
            end else if (s3_adv && s2_v) begin
                s3_fp <= s2_fp;
                s3_fl <= s2_fl;
            end
        end

        assign fp_o[n*FPW +: FPW] = s3_fp;
        assign flags_o[n*3 +: 3]  = s3_fl;
    end

endmodule

// File: tb/tb_floating_point_multiplier_array.sv
// Directed bench for floating_point_multiplier_array (8/23 format, 4 lanes)
// with a queue scoreboard filled on input acceptance.
module tb_floating_point_multiplier_array;

    localparam int unsigned EXP_WIDTH  = 8;
    localparam int unsigned FRAC_WIDTH = 23;
    localparam int unsigned LANES      = 4;
    localparam int unsigned FPW        = 1 + EXP_WIDTH + FRAC_WIDTH;

`ifdef FP_MUL_ARRAY_RNE_EN
    localparam logic [31:0] TIE_RES = 32'h3F801000;
`else
    localparam logic [31:0] TIE_RES = 32'h3F801001;
`endif

    logic                   clk_i;
    logic                   rst_ni;
    logic [LANES*FPW-1:0]   fp_a_i, fp_b_i;
    logic [LANES-1:0]       lane_en_i;
    logic                   valid_i;
    logic                   ready_o;
    logic [LANES*FPW-1:0]   fp_o;
    logic [LANES*3-1:0]     flags_o;
    logic                   valid_o;
    logic                   ready_i;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [139:0] exp_q[$];
    logic [139:0] mon_e;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_fp;
    logic [11:0]  prev_fl;

    logic [31:0] stall_vals [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                                    32'h40A00000, 32'h40C00000, 32'h40E00000};

    floating_point_multiplier_array #(
        .EXP_WIDTH (EXP_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH),
        .LANES     (LANES)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .fp_a_i   (fp_a_i),
        .fp_b_i   (fp_b_i),
        .lane_en_i(lane_en_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .fp_o     (fp_o),
        .flags_o  (flags_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [139:0] obs, input logic [139:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one beat (called just after a rising edge); expected lanes are
    // zeroed where the lane is disabled
    task automatic send(input logic [127:0] a, input logic [127:0] b, input logic [3:0] en,
                        input logic [127:0] efp, input logic [11:0] efl);
        logic [127:0] mfp;
        logic [11:0]  mfl;
        bit           ok;
        ok  = 1'b0;
        mfp = efp;
        mfl = efl;
        for (int n = 0; n < 4; n++) begin
            if (!en[n]) begin
                mfp[n*32 +: 32] = '0;
                mfl[n*3 +: 3]   = '0;
            end
        end
        fp_a_i    = a;
        fp_b_i    = b;
        lane_en_i = en;
        valid_i   = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk_i);
            if (ready_o === 1'b1) begin
                exp_q.push_back({mfp, mfl});
                ok = 1'b1;
            end
            step();
        end
        valid_i = 1'b0;
        check("send_accept", 140'(ok), 140'(1));
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) step();
        check("drain_empty", 140'(exp_q.size()), 140'(0));
        step();
    endtask

    // Output monitor: scoreboard pop on transfer, stability check on stall
    always @(negedge clk_i) begin
        if (rst_ni && prev_stall) begin
            check("hold_fp", 140'(fp_o), 140'(prev_fp));
            check("hold_flags", 140'(flags_o), 140'(prev_fl));
            check("hold_valid", 140'(valid_o), 140'(1));
        end
        if (rst_ni && valid_o && ready_i) begin
            n_cmp++;
            assert (exp_q.size() > 0)
            else begin
                n_err++;
                $error("FAIL unexpected_beat: observed fp %0h expected no beat", fp_o);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("beat_fp", 140'(fp_o), 140'(mon_e[139:12]));
                check("beat_flags", 140'(flags_o), 140'(mon_e[11:0]));
            end
        end
        prev_stall = rst_ni && valid_o && !ready_i;
        prev_fp    = fp_o;
        prev_fl    = flags_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni    = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        fp_a_i    = '0;
        fp_b_i    = '0;
        lane_en_i = '0;

        // Reset state
        repeat (2) step();
        @(negedge clk_i);
        check("reset_ready_low", 140'(ready_o), 140'(0));
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset_valid_o", 140'(valid_o), 140'(0));
        check("reset_fp_o", 140'(fp_o), 140'(0));
        check("reset_flags_o", 140'(flags_o), 140'(0));
        check("release_ready", 140'(ready_o), 140'(1));
        step();
        ready_i = 1'b1;

        // 1.5 * 2 = 3 on lane 0 only, latency of three cycles
        send({32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h3FC00000},
             {32'h00000000, 32'h00000000, 32'h00000000, 32'h40000000},
             4'b0001, {96'h0, 32'h40400000}, 12'h000);
        @(negedge clk_i);
        check("latency_c1", 140'(valid_o), 140'(0));
        @(negedge clk_i);
        check("latency_c2", 140'(valid_o), 140'(0));
        @(negedge clk_i);
        check("latency_c3", 140'(valid_o), 140'(1));
        step();

        // Invalid, signed infinity, overflow, underflow
        send({32'h00800000, 32'h7F7FFFFF, 32'hFF800000, 32'h00000000},
             {32'h3F000000, 32'h40000000, 32'h40000000, 32'h7F800000},
             4'b1111, {32'h00000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000},
             {3'b001, 3'b010, 3'b000, 3'b100});
        // Tie rounding, rounding carry-out, exponent-0 renormalise, carry product
        send({32'h3FFFFFFF, 32'h00FFFFFF, 32'h3FFFFFFE, 32'h3F800800},
             {32'h3FFFFFFF, 32'h3F7FFFFF, 32'h3F800001, 32'h3F800800},
             4'b1111, {32'h407FFFFE, 32'h00FFFFFE, 32'h40000000, TIE_RES}, 12'h000);
        // NaN input, negative zero, inf*zero, subnormal as zero
        send({32'h00000001, 32'h7F800000, 32'h80000000, 32'hFFC00001},
             {32'h7F000000, 32'h80000000, 32'h3F800000, 32'h3F800000},
             4'b1111, {32'h00000000, 32'h7FC00000, 32'h80000000, 32'h7FC00000},
             {3'b000, 3'b100, 3'b000, 3'b100});
        // Signed underflow, -inf*-2, negative overflow, lane 3 disabled
        send({32'hBF800000, 32'hFF7FFFFF, 32'hFF800000, 32'h80800000},
             {32'h3F800000, 32'h40000000, 32'hC0000000, 32'h00800000},
             4'b0111, {32'hBF800000, 32'hFF800000, 32'h7F800000, 32'h80000000},
             {3'b000, 3'b010, 3'b000, 3'b001});
        // Ordinary normal products
        send({32'h3F800000, 32'h3F000000, 32'hC0400000, 32'h40400000},
             {32'h3F800000, 32'h3F000000, 32'h40400000, 32'h40400000},
             4'b1111, {32'h3F800000, 32'h3E800000, 32'hC1100000, 32'h41100000}, 12'h000);
        drain();

        // Six back-to-back beats with downstream stalled for cycles 4-7
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send({4{32'h3F800000}}, {4{stall_vals[k]}}, 4'hF, {4{stall_vals[k]}}, 12'h000);
            end
            begin
                repeat (3) step();
                ready_i = 1'b0;
                @(negedge clk_i);
                check("stall_ready_low", 140'(ready_o), 140'(0));
                repeat (4) step();
                ready_i = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight
        ready_i = 1'b0;
        send({4{32'h40400000}}, {4{32'h40400000}}, 4'hF, {4{32'h41100000}}, 12'h000);
        send({4{32'h3FC00000}}, {4{32'h40000000}}, 4'hF, {4{32'h40400000}}, 12'h000);
        send({4{32'h3F800000}}, {4{32'h40000000}}, 4'hF, {4{32'h40000000}}, 12'h000);
        check("inflight_valid", 140'(valid_o), 140'(1));
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("rst_ready_low", 140'(ready_o), 140'(0));
        step();
        rst_ni = 1'b1;
        exp_q.delete();
        @(negedge clk_i);
        check("rst_valid_low", 140'(valid_o), 140'(0));
        check("rst_fp_zero", 140'(fp_o), 140'(0));
        check("rst_ready_release", 140'(ready_o), 140'(1));
        step();
        ready_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk_i);
            check("no_stale", 140'(valid_o), 140'(0));
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
